// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed 7-segment driver with per-frame snapshot, ghosting guard
// and leading-zero blanking.
module seg_scan #(
  parameter int NUM_DIG     = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int GUARD       = 2,
  parameter int SEG_ACT_LOW = 1,
  parameter int DIG_ACT_LOW = 1,
  parameter int BLANK_LZ    = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [4*NUM_DIG-1:0] dig_bus,
  input  logic [NUM_DIG-1:0]   dp_in,
  input  logic                 en,
  output logic [6:0]           seg_out,
  output logic                 dp_out,
  output logic [NUM_DIG-1:0]   dig_sel,
  output logic                 frame_tick
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(NUM_DIG);
  localparam logic SL = SEG_ACT_LOW != 0;
  localparam logic DL = DIG_ACT_LOW != 0;
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40
  };
  logic [DW-1:0]        div_q, div_d;
  logic [SW-1:0]        slot_q, slot_d;
  logic [4*NUM_DIG-1:0] snap_dig_q;
  logic [NUM_DIG-1:0]   snap_dp_q;
  logic [6:0]           seg_q, seg_d;
  logic                 dp_q, dp_d;
  logic [NUM_DIG-1:0]   sel_q, sel_d;
  logic                 tick_q;
  logic                 div_end, frame_end, show, blank;
  logic [3:0]           cur;
  assign div_end   = div_q == DW'(SCAN_DIV - 1);
  assign frame_end = div_end && slot_q == SW'(NUM_DIG - 1);
  assign div_d     = div_end ? '0 : div_q + 1'b1;
  assign slot_d    = !div_end ? slot_q : frame_end ? '0 : slot_q + 1'b1;
  assign cur       = snap_dig_q[{slot_q, 2'b00} +: 4];
  assign show      = en && div_q >= DW'(GUARD);
  // A digit is a leading zero when it and every more significant digit are zero
  always_comb begin
    blank = BLANK_LZ != 0 && slot_q != '0;
    for (int j = 0; j < NUM_DIG; j++)
      if (SW'(j) >= slot_q && snap_dig_q[4*j +: 4] != 4'd0) blank = 1'b0;
  end
  assign seg_d = ((show && !blank) ? SEG_LUT[cur] : 7'h00) ^ {7{SL}};
  assign dp_d  = (show && snap_dp_q[slot_q]) ^ SL;
  assign sel_d = (show ? NUM_DIG'(1) << slot_q : '0) ^ {NUM_DIG{DL}};
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q      <= '0;
      slot_q     <= '0;
      snap_dig_q <= '0;
      snap_dp_q  <= '0;
      seg_q      <= {7{SL}};
      dp_q       <= SL;
      sel_q      <= {NUM_DIG{DL}};
      tick_q     <= 1'b0;
    end else begin
      div_q  <= div_d;
      slot_q <= slot_d;
      if (frame_end) begin
        snap_dig_q <= dig_bus;
        snap_dp_q  <= dp_in;
      end
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      sel_q  <= sel_d;
      tick_q <= frame_end;
    end
  end
  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign dig_sel    = sel_q;
  assign frame_tick = tick_q;
endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: directed vector table plus hand sequences for seg_scan (4 digits, 8-cycle slots).
module tb_seg_scan;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] dig_bus = '0;
  logic [3:0]  dp_in = '0;
  logic        en = 1'b1;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  dig_sel;
  logic        frame_tick;
  int checks = 0;
  int failures = 0;

  seg_scan #(.NUM_DIG(4), .SCAN_DIV(8), .GUARD(2), .SEG_ACT_LOW(1), .DIG_ACT_LOW(1), .BLANK_LZ(1)) dut (
    .clk(clk), .reset_n(reset_n), .dig_bus(dig_bus), .dp_in(dp_in), .en(en),
    .seg_out(seg_out), .dp_out(dp_out), .dig_sel(dig_sel), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] bus;
    logic [3:0]  dp;
    logic [1:0]  slot;
    logic [6:0]  seg;
    logic        dpo;
    logic [3:0]  sel;
  } vec_t;
  vec_t tv [17];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_tick();
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (frame_tick) return;
    end
    chk("tick_timeout", 16'd0, 16'd1);
  endtask

  task automatic count_to_tick(output int n);
    n = 0;
    while (n < 80) begin
      @(negedge clk);
      n++;
      if (frame_tick) return;
    end
  endtask

  initial begin
    int n;
    tv[0]  = '{16'h1234, 4'h0, 2'd0, 7'h19, 1'b1, 4'hE};
    tv[1]  = '{16'h1234, 4'h0, 2'd1, 7'h30, 1'b1, 4'hD};
    tv[2]  = '{16'h1234, 4'h0, 2'd2, 7'h24, 1'b1, 4'hB};
    tv[3]  = '{16'h1234, 4'h0, 2'd3, 7'h79, 1'b1, 4'h7};
    tv[4]  = '{16'h0005, 4'h0, 2'd0, 7'h12, 1'b1, 4'hE};
    tv[5]  = '{16'h0005, 4'h0, 2'd1, 7'h7F, 1'b1, 4'hD};
    tv[6]  = '{16'h0005, 4'h0, 2'd3, 7'h7F, 1'b1, 4'h7};
    tv[7]  = '{16'h0000, 4'h0, 2'd0, 7'h40, 1'b1, 4'hE};
    tv[8]  = '{16'h0000, 4'h0, 2'd2, 7'h7F, 1'b1, 4'hB};
    tv[9]  = '{16'h00A0, 4'h0, 2'd1, 7'h3F, 1'b1, 4'hD};
    tv[10] = '{16'h00A0, 4'h0, 2'd0, 7'h40, 1'b1, 4'hE};
    tv[11] = '{16'h0005, 4'h4, 2'd2, 7'h7F, 1'b0, 4'hB};
    tv[12] = '{16'h9876, 4'h1, 2'd0, 7'h02, 1'b0, 4'hE};
    tv[13] = '{16'h9876, 4'h1, 2'd3, 7'h10, 1'b1, 4'h7};
    tv[14] = '{16'h0F00, 4'h0, 2'd2, 7'h3F, 1'b1, 4'hB};
    tv[15] = '{16'h0F00, 4'h0, 2'd3, 7'h7F, 1'b1, 4'h7};
    tv[16] = '{16'h0F00, 4'h0, 2'd1, 7'h40, 1'b1, 4'hD};

    // Reset values and first frame_tick latency
    repeat (3) @(negedge clk);
    chk("rst_seg", 16'(seg_out), 16'h7F);
    chk("rst_dp", 16'(dp_out), 16'h1);
    chk("rst_sel", 16'(dig_sel), 16'hF);
    chk("rst_tick", 16'(frame_tick), 16'h0);
    reset_n = 1'b1;
    count_to_tick(n);
    chk("first_tick_latency", 16'(n), 16'd32);
    @(negedge clk);
    chk("tick_width", 16'(frame_tick), 16'h0);
    count_to_tick(n);
    chk("tick_period", 16'(n + 1), 16'd32);

    for (int i = 0; i < 17; i++) begin
      dig_bus = tv[i].bus;
      dp_in   = tv[i].dp;
      wait_tick();
      repeat (8 * int'(tv[i].slot) + 5) @(negedge clk);
      chk($sformatf("vec%0d_seg", i), 16'(seg_out), 16'(tv[i].seg));
      chk($sformatf("vec%0d_dp", i), 16'(dp_out), 16'(tv[i].dpo));
      chk($sformatf("vec%0d_sel", i), 16'(dig_sel), 16'(tv[i].sel));
    end

    // Guard window at the start of slots 0 and 1
    dig_bus = 16'h1234;
    dp_in   = 4'h0;
    wait_tick();
    wait_tick();
    @(negedge clk);
    chk("guard_s0_c1", 16'(dig_sel), 16'hF);
    @(negedge clk);
    chk("guard_s0_c2", 16'(dig_sel), 16'hF);
    chk("guard_s0_seg", 16'(seg_out), 16'h7F);
    @(negedge clk);
    chk("guard_s0_c3", 16'(dig_sel), 16'hE);
    repeat (6) @(negedge clk);
    chk("guard_s1_c9", 16'(dig_sel), 16'hF);
    @(negedge clk);
    chk("guard_s1_c10", 16'(dig_sel), 16'hF);
    @(negedge clk);
    chk("guard_s1_c11", 16'(dig_sel), 16'hD);

    // Mid-frame input change is held off until the next snapshot
    dig_bus = 16'h5678;
    repeat (18) @(negedge clk);
    chk("tear_s3_seg", 16'(seg_out), 16'h79);
    wait_tick();
    repeat (5) @(negedge clk);
    chk("new_frame_s0_seg", 16'(seg_out), 16'h00);

    // Display disable darkens outputs next cycle; tick period is unchanged
    en = 1'b0;
    @(negedge clk);
    chk("en0_sel", 16'(dig_sel), 16'hF);
    chk("en0_seg", 16'(seg_out), 16'h7F);
    wait_tick();
    count_to_tick(n);
    chk("en0_tick_period", 16'(n), 16'd32);
    repeat (5) @(negedge clk);
    chk("en0_s0_dark", 16'(dig_sel), 16'hF);
    en = 1'b1;
    @(negedge clk);
    chk("en1_s0_sel", 16'(dig_sel), 16'hE);

    // Asynchronous reset during slot 2
    dig_bus = 16'h1234;
    wait_tick();
    wait_tick();
    repeat (21) @(negedge clk);
    chk("pre_rst_sel", 16'(dig_sel), 16'hB);
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst_sel", 16'(dig_sel), 16'hF);
    chk("async_rst_seg", 16'(seg_out), 16'h7F);
    chk("async_rst_dp", 16'(dp_out), 16'h1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_seg", 16'(seg_out), 16'h40);
    chk("post_rst_sel", 16'(dig_sel), 16'hE);
    count_to_tick(n);
    chk("post_rst_tick", 16'(n + 5), 16'd32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
